// File: rtl/gaussian_blur.sv
// 3x3 Gaussian blur stage: streams a raster frame from a source BRAM through two
// line buffers and a 3x3 window, writing the filtered frame to a destination BRAM.
module gaussian_blur #(
  parameter int unsigned WIDTH  = 320,
  parameter int unsigned HEIGHT = 240,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blur_start,
  output logic              blur_done,
  output logic              busy,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_we
);

  localparam int unsigned NPIX  = WIDTH * HEIGHT;
  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned COL_W = $clog2(WIDTH);
  localparam int unsigned ROW_W = $clog2(HEIGHT);
  localparam int unsigned FL_W  = $clog2(WIDTH + 2);
  localparam int unsigned SUM_W = PIX_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t state, state_nxt;

  logic              start_c;
  logic              last_addr_c;
  logic              last_write_c;
  logic [FL_W-1:0]   flush_cnt;
  logic              feed_vld;
  logic              feed_dummy;
  logic [PIX_W-1:0]  pix_c;
  logic [COL_W-1:0]  col;
  logic [CNT_W-1:0]  k_cnt;
  logic              emit;
  logic [COL_W-1:0]  ox;
  logic [ROW_W-1:0]  oy;
  logic [ADDR_W-1:0] wr_idx;
  logic              border_c;
  logic [SUM_W-1:0]  sum_c;
  logic [PIX_W-1:0]  blur_c;

  logic [PIX_W-1:0]  lb1 [WIDTH];
  logic [PIX_W-1:0]  lb2 [WIDTH];
  logic [PIX_W-1:0]  t0, t1, t2, m0, m1, m2, b0, b1, b2;

  assign start_c      = (state == S_IDLE) && blur_start;
  assign last_addr_c  = (src_addr == ADDR_W'(NPIX - 1));
  assign last_write_c = dst_we && (dst_addr == ADDR_W'(NPIX - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (blur_start) state_nxt = S_READ;
      S_READ:  if (last_addr_c) state_nxt = S_FLUSH;
      S_FLUSH: if (last_write_c) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status outputs, registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      blur_done <= 1'b0;
    end else begin
      busy      <= (state_nxt == S_READ) || (state_nxt == S_FLUSH);
      blur_done <= (state_nxt == S_DONE);
    end
  end

  // Source address generation and feed control (real pixels, then WIDTH+1 dummies)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_addr   <= '0;
      flush_cnt  <= '0;
      feed_vld   <= 1'b0;
      feed_dummy <= 1'b0;
    end else begin
      if (start_c) begin
        src_addr  <= '0;
        flush_cnt <= '0;
      end else if (state == S_READ && !last_addr_c) begin
        src_addr <= src_addr + ADDR_W'(1);
      end
      if (state == S_FLUSH && flush_cnt != FL_W'(WIDTH + 1))
        flush_cnt <= flush_cnt + FL_W'(1);
      feed_vld   <= (state == S_READ) ||
                    (state == S_FLUSH && flush_cnt != FL_W'(WIDTH + 1));
      feed_dummy <= (state == S_FLUSH);
    end
  end

  assign pix_c = feed_dummy ? '0 : src_data;

  // Window and line buffers; contents need no reset since feed_vld gates all use
  always_ff @(posedge clk) begin
    if (feed_vld) begin
      t0 <= t1;  t1 <= t2;  t2 <= lb2[col];
      m0 <= m1;  m1 <= m2;  m2 <= lb1[col];
      b0 <= b1;  b1 <= b2;  b2 <= pix_c;
      lb2[col] <= lb1[col];
      lb1[col] <= pix_c;
    end
  end

  // Feed position tracking; output for (x,y) is ready once pixel (x+1,y+1) is fed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col   <= '0;
      k_cnt <= '0;
      emit  <= 1'b0;
    end else if (start_c) begin
      col   <= '0;
      k_cnt <= '0;
      emit  <= 1'b0;
    end else if (feed_vld) begin
      col   <= (col == COL_W'(WIDTH - 1)) ? '0 : col + COL_W'(1);
      k_cnt <= k_cnt + CNT_W'(1);
      emit  <= (k_cnt >= CNT_W'(WIDTH + 1));
    end else begin
      emit  <= 1'b0;
    end
  end

  assign border_c = (ox == '0) || (ox == COL_W'(WIDTH - 1)) ||
                    (oy == '0) || (oy == ROW_W'(HEIGHT - 1));

  // Kernel [1 2 1; 2 4 2; 1 2 1] with round-half-up
  always_comb begin
    sum_c = SUM_W'(t0) + SUM_W'(t2) + SUM_W'(b0) + SUM_W'(b2)
          + (SUM_W'(t1) << 1) + (SUM_W'(m0) << 1)
          + (SUM_W'(m2) << 1) + (SUM_W'(b1) << 1)
          + (SUM_W'(m1) << 2) + SUM_W'(8);
    blur_c = PIX_W'(sum_c >> 4);
  end

  // Destination write stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_we   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
      wr_idx   <= '0;
      ox       <= '0;
      oy       <= '0;
    end else if (start_c) begin
      dst_we <= 1'b0;
      wr_idx <= '0;
      ox     <= '0;
      oy     <= '0;
    end else if (emit) begin
      dst_we   <= 1'b1;
      dst_addr <= wr_idx;
      dst_data <= border_c ? m1 : blur_c;
      wr_idx   <= wr_idx + ADDR_W'(1);
      if (ox == COL_W'(WIDTH - 1)) begin
        ox <= '0;
        oy <= oy + ROW_W'(1);
      end else begin
        ox <= ox + COL_W'(1);
      end
    end else begin
      dst_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gaussian_blur.sv
// Self-checking bench for gaussian_blur: frame-level reference model, per-write
// compare process, and literal spot checks on known patterns.
module tb_gaussian_blur;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  localparam int PW = 8;
  localparam int AW = 17;
  localparam int BUDGET = N + W + 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blur_start = 1'b0;
  logic          blur_done;
  logic          busy;
  logic [AW-1:0] src_addr;
  logic [PW-1:0] src_data;
  logic [AW-1:0] dst_addr;
  logic [PW-1:0] dst_data;
  logic          dst_we;

  int src_mem [N];
  int dst_mem [N];
  int exp_mem [N];
  int exp_next;
  int write_cnt;
  int done_cnt;
  int nchk = 0;
  int nerr = 0;

  gaussian_blur #(.WIDTH(W), .HEIGHT(H), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .blur_start(blur_start), .blur_done(blur_done),
    .busy(busy), .src_addr(src_addr), .src_data(src_data),
    .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we)
  );

  always #5 clk = ~clk;

  // Single-cycle source BRAM
  always @(posedge clk) begin
    if (int'(src_addr) < N) src_data <= PW'(src_mem[int'(src_addr)]);
    else                    src_data <= '0;
  end

  task automatic check(input string name, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Compare process: every write must be next in order and match the model
  always @(negedge clk) begin
    if (dst_we) begin
      check("dst_addr order", int'(dst_addr), exp_next);
      if (int'(dst_addr) < N) begin
        check("dst_data", int'(dst_data), exp_mem[int'(dst_addr)]);
        dst_mem[int'(dst_addr)] = int'(dst_data);
      end
      exp_next++;
      write_cnt++;
    end
    if (blur_done) done_cnt++;
  end

  function automatic int kw(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  task automatic build_model();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1) begin
          exp_mem[y*W+x] = src_mem[y*W+x];
        end else begin
          int s = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              s += kw(dx) * kw(dy) * src_mem[(y+dy)*W + x + dx];
          exp_mem[y*W+x] = (s + 8) / 16;
        end
      end
  endtask

  task automatic fill(input int kind);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        case (kind)
          0: src_mem[y*W+x] = 100;
          1: src_mem[y*W+x] = (x == 3 && y == 3) ? 160 : 0;
          2: src_mem[y*W+x] = 255;
          3: src_mem[y*W+x] = ((x + y) % 2 == 1) ? 255 : 0;
          4: src_mem[y*W+x] = (x + y * 8) % 256;
          default: src_mem[y*W+x] = int'($urandom_range(0, 255));
        endcase
        dst_mem[y*W+x] = -1;
      end
    build_model();
  endtask

  // One frame; optional second start at restart_at, optional reset at reset_at
  task automatic run_frame(input string tag, input int restart_at, input int reset_at);
    int cyc;
    bit got;
    exp_next  = 0;
    write_cnt = 0;
    done_cnt  = 0;
    @(negedge clk);
    blur_start = 1'b1;
    @(negedge clk);
    blur_start = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (cyc <= BUDGET + 6 && !got) begin
      if (cyc == restart_at) blur_start = 1'b1;
      else                   blur_start = 1'b0;
      if (cyc == reset_at) begin
        rst_n = 1'b0;
        #1;
        check({tag, " busy in reset"}, int'(busy), 0);
        check({tag, " dst_we in reset"}, int'(dst_we), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (BUDGET + 10) @(negedge clk);
        check({tag, " done after abort"}, done_cnt, 0);
        return;
      end
      if (blur_done) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    blur_start = 1'b0;
    check({tag, " done seen"}, int'(got), 1);
    check({tag, " latency ok"}, int'(cyc <= BUDGET), 1);
    check({tag, " busy at done"}, int'(busy), 0);
    repeat (8) @(negedge clk);
    check({tag, " write count"}, write_cnt, N);
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(blur_done), 0);
    check("rst we", int'(dst_we), 0);
    check("rst src_addr", int'(src_addr), 0);
    check("rst dst_addr", int'(dst_addr), 0);
    check("rst dst_data", int'(dst_data), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    fill(0);
    run_frame("uniform", -1, -1);
    check("uniform (4,2)", dst_mem[2*W+4], 100);

    fill(1);
    run_frame("impulse", -1, -1);
    check("imp (3,3)", dst_mem[3*W+3], 40);
    check("imp (2,3)", dst_mem[3*W+2], 20);
    check("imp (3,2)", dst_mem[2*W+3], 20);
    check("imp (2,2)", dst_mem[2*W+2], 10);
    check("imp (4,4)", dst_mem[4*W+4], 10);
    check("imp (5,5)", dst_mem[5*W+5], 0);
    for (int x = 0; x < W; x++) begin
      check("imp top", dst_mem[x], 0);
      check("imp bottom", dst_mem[(H-1)*W+x], 0);
    end

    fill(2);
    run_frame("sat", -1, -1);
    check("sat (3,3)", dst_mem[3*W+3], 255);

    fill(3);
    run_frame("checker", -1, -1);
    check("chk (1,1)", dst_mem[1*W+1], 128);
    check("chk (2,1)", dst_mem[1*W+2], 128);

    fill(4);
    run_frame("ramp", -1, -1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        if (x == 0 || y == 0 || x == W - 1 || y == H - 1)
          check("ramp border", dst_mem[y*W+x], (x + y * 8) % 256);

    fill(5);
    run_frame("restart", 10, -1);
    fill(5);
    run_frame("second", -1, -1);

    fill(5);
    run_frame("abort", -1, 20);
    fill(5);
    run_frame("after_reset", -1, -1);

    for (int i = 0; i < 2; i++) begin
      fill(5);
      run_frame("random", -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/gaussian_blur.md
Name: gaussian_blur

Overview:
- 3x3 Gaussian blur stage. Launched by the main FSM's one-cycle blur_start pulse; signals completion with a one-cycle blur_done pulse that advances the FSM to edge detection.
- Streams a grayscale frame in raster order out of a source BRAM and writes the filtered frame to a destination BRAM.
- Uses two internal line buffers, so every source pixel is read exactly once.

Parameters:
- WIDTH, 320, frame width in pixels (min 4)
- HEIGHT, 240, frame height in pixels (min 4)
- PIX_W, 8, bits per grayscale pixel
- ADDR_W, 17, BRAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- blur_start  in  1  one-cycle start pulse from the main FSM
- blur_done  out  1  one-cycle pulse after the last destination write
- busy  out  1  high from the cycle after an accepted start until blur_done
- src_addr  out  ADDR_W  source BRAM read address
- src_data  in  PIX_W  source BRAM read data, valid one cycle after src_addr
- dst_addr  out  ADDR_W  destination BRAM write address
- dst_data  out  PIX_W  destination write data
- dst_we  out  1  destination write enable

Behaviour:
- Reset, asynchronous, rst_n low:
  - State returns to IDLE.
  - blur_done, busy, dst_we are 0; src_addr, dst_addr, dst_data are 0.
  - Line buffer and window contents are don't-care.
  - Reset asserted mid-frame aborts the frame: no blur_done, no further writes.
- States:
  - IDLE -> READ on blur_start.
  - READ: src_addr advances 0..WIDTH*HEIGHT-1, one address per cycle, no stalls.
    - READ -> FLUSH the cycle after the last address is issued.
  - FLUSH: feeds WIDTH+1 dummy pixels through the window so the final row and column are emitted.
    - FLUSH -> DONE when the last write has occurred.
  - DONE: blur_done=1 for exactly one cycle -> IDLE.
- blur_start is ignored whenever not in IDLE.
- A blur_start arriving in the same cycle as blur_done is ignored. The FSM never sends one there.
- Window: 3x3 register window, fed by two WIDTH-deep line buffers that account for src_data's 1-cycle read latency. The output for pixel (x,y) is produced once source pixel (x+1,y+1) (or its dummy) is in the window.
- Interior pixels (1<=x<=WIDTH-2, 1<=y<=HEIGHT-2):
  - Kernel [1 2 1; 2 4 2; 1 2 1].
  - Accumulate in PIX_W+4 bits; out = (sum + 8) >> 4, i.e. round half up.
  - The result never exceeds 2^PIX_W-1, so no saturation is needed.
- Border pixels (x=0, x=WIDTH-1, y=0, y=HEIGHT-1): out = the source pixel unchanged. The window never wraps across row ends.
- Writes:
  - Exactly WIDTH*HEIGHT dst_we pulses per frame.
  - dst_addr = y*WIDTH+x, strictly increasing from 0 with no gaps or repeats.
  - dst_data is valid in the same cycle as dst_we.
- Latency: blur_start to blur_done is at most WIDTH*HEIGHT + WIDTH + 8 cycles.
- busy falls in the cycle blur_done is asserted.
- Source and destination are separate memories. The block never writes src and never reads dst.

Test Plan:
(All with WIDTH=8, HEIGHT=6, single-cycle BRAM model.)
- Uniform frame, all pixels 100, one blur_start:
  - Required: 48 writes, addresses 0..47 in order, every value 100.
  - Required: exactly one blur_done, within 48+8+8 cycles.
- Impulse of 160 at (3,3), all other pixels 0:
  - Required values: (3,3)=40, (2,3)=20, (3,2)=20, (2,2)=10, (4,4)=10, (5,5)=0.
  - Required: border pixels all 0.
- Saturation/rounding, all pixels 255: every output is 255. Checkerboard of 0/255: interior outputs are 128 or 128, per (sum+8)>>4 worked by hand.
- Border copy: ramp src=(x+y*8) mod 256. Required: row 0, row 5, column 0 and column 7 equal the source exactly.
- Re-start while busy: pulse blur_start again at cycle 10. Required: no restart, write count stays 48, one blur_done. A second start after done runs a full second frame.
- Reset at cycle 20 mid-frame: busy=0, dst_we=0 immediately, no blur_done. A subsequent blur_start completes a correct frame.
